uart_sipo: RTL and testbench

//  Serial in, parallel out UART receiver; the receive-side counterpart of the team's PISO transmitter.

---
 rtl/uart_sipo.sv | 168 ++++++++++++++++
 tb/tb_uart_sipo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_sipo.sv
// rtl/uart_sipo.sv - serial-in parallel-out UART receiver with valid/ack output register
// Optional 2-of-3 majority sampling: define UART_SIPO_MAJORITY_EN.
module uart_sipo #(
    parameter int DIVIDER = 4096,
    parameter int CHAR_W  = 8,
    parameter int CNT_W   = $clog2(DIVIDER)
) (
    input  logic              clock_50M,
    input  logic              n_reset,
    input  logic              uart_rx_pin,
    input  logic              rx_ack,
    output logic [CHAR_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_frame_err,
    output logic              rx_overrun
);

    localparam int IDX_W = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;

    localparam logic [2:0] WAIT_IDLE = 3'd0;
    localparam logic [2:0] IDLE      = 3'd1;
    localparam logic [2:0] START     = 3'd2;
    localparam logic [2:0] DATA      = 3'd3;
    localparam logic [2:0] STOP      = 3'd4;

    logic              sync1;
    logic              rxs;
    logic [2:0]        state;
    logic [CNT_W-1:0]  counter;
    logic [IDX_W-1:0]  bit_idx;
    logic [CHAR_W-1:0] shift;
    logic              accept_pending;
    logic              at_sample;
    logic              sample;

    always_ff @(posedge clock_50M or negedge n_reset) begin
        if (!n_reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= uart_rx_pin;
            rxs   <= sync1;
        end
    end

`ifdef UART_SIPO_MAJORITY_EN
    // hist[0] is rxs one cycle ago, hist[1] two cycles ago; vote includes the live rxs
    logic [1:0] hist;

    always_ff @(posedge clock_50M or negedge n_reset) begin
        if (!n_reset) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rxs};
        end
    end

    always_comb begin
        sample = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
    end
`else
    always_comb begin
        sample = rxs;
    end
`endif

    // Start bit is sampled at half a bit period, every later bit a full period after that
    always_comb begin
        if (state == START) begin
            at_sample = (counter == CNT_W'(DIVIDER/2 - 1));
        end else begin
            at_sample = (counter == CNT_W'(DIVIDER - 1));
        end
    end

    always_ff @(posedge clock_50M or negedge n_reset) begin
        if (!n_reset) begin
            state          <= WAIT_IDLE;
            counter        <= '0;
            bit_idx        <= '0;
            shift          <= '0;
            accept_pending <= 1'b0;
            rx_frame_err   <= 1'b0;
        end else begin
            accept_pending <= 1'b0;
            rx_frame_err   <= 1'b0;
            case (state)
                WAIT_IDLE: begin
                    counter <= '0;
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    counter <= '0;
                    bit_idx <= '0;
                    if (!rxs) begin
                        state <= START;
                    end
                end
                START: begin
                    if (at_sample) begin
                        counter <= '0;
                        bit_idx <= '0;
                        state   <= sample ? IDLE : DATA;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                DATA: begin
                    if (at_sample) begin
                        shift   <= {sample, shift[CHAR_W-1:1]};
                        counter <= '0;
                        if (bit_idx == IDX_W'(CHAR_W - 1)) begin
                            bit_idx <= '0;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                STOP: begin
                    if (at_sample) begin
                        counter <= '0;
                        if (sample) begin
                            accept_pending <= 1'b1;
                            state          <= IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            state        <= WAIT_IDLE;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: begin
                    counter <= '0;
                    state   <= WAIT_IDLE;
                end
            endcase
        end
    end

    // An ack coinciding with an accept frees the register for the new char
    always_ff @(posedge clock_50M or negedge n_reset) begin
        if (!n_reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else if (accept_pending) begin
            if (!rx_valid || rx_ack) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
                if (rx_ack) begin
                    rx_overrun <= 1'b0;
                end
            end else begin
                rx_overrun <= 1'b1;
            end
        end else if (rx_ack && rx_valid) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_sipo.sv
// tb/tb_uart_sipo.sv - directed scoreboard bench for uart_sipo at 16 cycles per bit
module tb_uart_sipo;

    localparam int DIV = 16;

    logic       clock_50M = 1'b0;
    logic       n_reset = 1'b0;
    logic       uart_rx_pin = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;

    int         total = 0;
    int         bad = 0;
    int         fe_cnt = 0;
    int         rise_cnt = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] glitch_exp;
    int         r0;
    int         f0;

    always #5 clock_50M = ~clock_50M;

    uart_sipo #(.DIVIDER(DIV), .CHAR_W(8)) dut (
        .clock_50M    (clock_50M),
        .n_reset      (n_reset),
        .uart_rx_pin  (uart_rx_pin),
        .rx_ack       (rx_ack),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    always @(negedge clock_50M) begin
        if (rx_frame_err) fe_cnt++;
        if (rx_valid && !prev_valid) rise_cnt++;
        prev_valid = rx_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] ch, input logic stop_bit,
                              input int glitch_cyc, input int ack_cyc);
        logic [9:0] fr;
        fr = {stop_bit, ch, 1'b0};
        for (int c = 0; c < 10*DIV; c++) begin
            @(negedge clock_50M);
            uart_rx_pin = (c == glitch_cyc) ? 1'b1 : fr[c/DIV];
            rx_ack      = (c == ack_cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock_50M);
    endtask

    task automatic pulse_ack();
        @(negedge clock_50M);
        rx_ack = 1'b1;
        @(negedge clock_50M);
        rx_ack = 1'b0;
    endtask

    task automatic expect_char(input string tag);
        logic ok;
        logic [7:0] e;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rx_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock_50M);
        end
        check({tag, "_valid_seen"}, {31'd0, ok}, 32'd1);
        if (ok && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_data"}, {24'd0, rx_data}, {24'd0, e});
        end
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clock_50M);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_ferr", {31'd0, rx_frame_err}, 32'd0);
        check("rst_ovr", {31'd0, rx_overrun}, 32'd0);
        n_reset = 1'b1;
        idle(400);
        check("idle_no_valid", rise_cnt, 0);
        check("idle_no_ferr", fe_cnt, 0);

        // single frame, held until ack
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, -1, -1);
        expect_char("a5");
        idle(50);
        check("a5_held_data", {24'd0, rx_data}, 32'h A5);
        check("a5_held_valid", {31'd0, rx_valid}, 32'd1);
        pulse_ack();
        check("a5_ack_clears", {31'd0, rx_valid}, 32'd0);

        // short low pulse is a false start
        r0 = rise_cnt;
        f0 = fe_cnt;
        @(negedge clock_50M);
        uart_rx_pin = 1'b0;
        idle(4);
        uart_rx_pin = 1'b1;
        idle(40);
        check("false_start_valid", rise_cnt - r0, 0);
        check("false_start_ferr", fe_cnt - f0, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, -1, -1);
        expect_char("after_false");
        pulse_ack();

        // bad stop bit followed by a held-low line
        r0 = rise_cnt;
        f0 = fe_cnt;
        send_frame(8'h3C, 1'b0, -1, -1);
        @(negedge clock_50M);
        uart_rx_pin = 1'b0;
        idle(47);
        uart_rx_pin = 1'b1;
        idle(40);
        check("ferr_pulses", fe_cnt - f0, 1);
        check("ferr_no_valid", rise_cnt - r0, 0);
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1, -1, -1);
        expect_char("after_ferr");
        pulse_ack();
        idle(20);

        // back-to-back frames without ack: second char dropped
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h22, 1'b1, -1, -1);
        idle(5);
        expect_char("ovr_first");
        check("ovr_flag", {31'd0, rx_overrun}, 32'd1);
        pulse_ack();
        check("ovr_ack_valid", {31'd0, rx_valid}, 32'd0);
        check("ovr_ack_flag", {31'd0, rx_overrun}, 32'd0);
        idle(20);

        // ack on the accept cycle of the second frame
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, -1);
        expect_char("ackacc_first");
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1, -1, 10*DIV - 5);
        idle(5);
        expect_char("ackacc_second");
        check("ackacc_no_ovr", {31'd0, rx_overrun}, 32'd0);
        pulse_ack();
        idle(20);

        // one-cycle glitch at the sample point of data bit 3
`ifdef UART_SIPO_MAJORITY_EN
        glitch_exp = 8'h00;
`else
        glitch_exp = 8'h08;
`endif
        exp_q.push_back(glitch_exp);
        send_frame(8'h00, 1'b1, 4*DIV + 8, -1);
        expect_char("glitch");
        pulse_ack();
        idle(20);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
